// File: rtl/hash_state_bank_if.sv
// hash_state_bank_if: request/response bundle for the SHA-256 state bank.
// The master side drives read, write and init requests. The slave side
// returns read data, the busy flag and the per-bank dirty bits.
interface hash_state_bank_if #(
    parameter int NUM_BANKS = 4,
    parameter int WORD_W    = 32,
    parameter int SEL_W     = 4
);
    logic                   rd_req;
    logic [SEL_W-1:0]       rd_sel;
    logic                   rd_valid;
    logic                   rd_err;
    logic [8*WORD_W-1:0]    rd_state;

    logic                   wr_en;
    logic [SEL_W-1:0]       wr_sel;
    logic [8*WORD_W-1:0]    wr_state;

    logic                   init_en;
    logic [SEL_W-1:0]       init_sel;

    logic                   busy;
    logic [NUM_BANKS-1:0]   bank_dirty;

    modport master (
        output rd_req, rd_sel, wr_en, wr_sel, wr_state, init_en, init_sel,
        input  rd_valid, rd_err, rd_state, busy, bank_dirty
    );

    modport slave (
        input  rd_req, rd_sel, wr_en, wr_sel, wr_state, init_en, init_sel,
        output rd_valid, rd_err, rd_state, busy, bank_dirty
    );
endinterface

// File: rtl/hash_state_bank.sv
// hash_state_bank: NUM_BANKS registered copies of the SHA-256 working state
// (A..H, with A in the MSBs). It has one registered read port, one write
// port, and per-bank reload of the SHA-256 IV. After reset, an init
// sequencer loads the IV into every bank before it accepts any request.
// Optional build macro HASH_STATE_BANK_ACCUM_EN: when it is defined, a write
// adds the incoming words to the stored words (the SHA-256 final addition).
// When it is not defined, a write overwrites the bank.
module hash_state_bank #(
    parameter int NUM_BANKS = 4,
    parameter int WORD_W    = 32,
    parameter int SEL_W     = 4
) (
    input  logic clk,
    input  logic rst,
    hash_state_bank_if.slave bus
);
    localparam int STATE_W = 8 * WORD_W;

    // The IV is packed A..H from the MSBs down. Narrow words keep the low bits.
    function automatic logic [STATE_W-1:0] build_iv();
        logic [255:0]         full;
        logic [STATE_W-1:0]   iv;
        full = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        iv = '0;
        for (int w = 0; w < 8; w++) begin
            iv[w*WORD_W +: WORD_W] = full[w*32 +: WORD_W];
        end
        return iv;
    endfunction

    localparam logic [STATE_W-1:0] IV = build_iv();

`ifdef HASH_STATE_BANK_ACCUM_EN
    // Each word is added on its own, so no carry crosses a word boundary.
    function automatic logic [STATE_W-1:0] accumulate(
        input logic [STATE_W-1:0] old_state,
        input logic [STATE_W-1:0] add_state
    );
        logic [STATE_W-1:0] sum;
        for (int w = 0; w < 8; w++) begin
            sum[w*WORD_W +: WORD_W] = old_state[w*WORD_W +: WORD_W]
                                    + add_state[w*WORD_W +: WORD_W];
        end
        return sum;
    endfunction
`endif

    typedef enum logic {
        ST_INIT_ALL,
        ST_IDLE
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       cnt_q, cnt_d;
    logic [STATE_W-1:0]     bank_q [NUM_BANKS];
    logic [STATE_W-1:0]     bank_d [NUM_BANKS];
    logic [NUM_BANKS-1:0]   dirty_q, dirty_d;
    logic [STATE_W-1:0]     rd_state_q, rd_state_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   rd_err_q, rd_err_d;

    // Sequencer, request servicing and read capture. A read uses bank_q, so a
    // read and a write to the same bank return the data from before the write.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dirty_d    = dirty_q;
        rd_state_d = rd_state_q;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_d[i] = bank_q[i];
        end

        case (state_q)
            ST_INIT_ALL: begin
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (cnt_q == SEL_W'(i)) begin
                        bank_d[i] = IV;
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SEL_W'(NUM_BANKS - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            ST_IDLE: begin
                if (bus.rd_req) begin
                    rd_err_d = 1'b1;
                    for (int i = 0; i < NUM_BANKS; i++) begin
                        if (bus.rd_sel == SEL_W'(i)) begin
                            rd_err_d   = 1'b0;
                            rd_valid_d = 1'b1;
                            rd_state_d = bank_q[i];
                        end
                    end
                end

                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (bus.init_en && bus.init_sel == SEL_W'(i)) begin
                        bank_d[i]  = IV;
                        dirty_d[i] = 1'b0;
                    end else if (bus.wr_en && bus.wr_sel == SEL_W'(i)) begin
`ifdef HASH_STATE_BANK_ACCUM_EN
                        bank_d[i]  = accumulate(bank_q[i], bus.wr_state);
`else
                        bank_d[i]  = bus.wr_state;
`endif
                        dirty_d[i] = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_INIT_ALL;
                cnt_d   = '0;
            end
        endcase
    end

    // Control and read-port registers. Reset restarts the init sequence and
    // cancels any read pulse that is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT_ALL;
            cnt_q      <= '0;
            dirty_q    <= '0;
            rd_state_q <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dirty_q    <= dirty_d;
            rd_state_q <= rd_state_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    // Bank storage needs no reset, because the init sequencer loads every bank.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            bank_q[i] <= bank_d[i];
        end
    end

    assign bus.rd_state   = rd_state_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.busy       = (state_q == ST_INIT_ALL);
    assign bus.bank_dirty = dirty_q;
endmodule

// File: tb/tb_hash_state_bank.sv
// tb_hash_state_bank: scoreboard bench for hash_state_bank. The stimulus
// tasks update a word-level model of the banks and queue the expected read
// responses. A monitor pops the queue on every rd_valid or rd_err pulse.
module tb_hash_state_bank;
    localparam int NB  = 4;
    localparam int W   = 32;
    localparam int SW  = 4;
    localparam int STW = 8 * W;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hash_state_bank_if #(.NUM_BANKS(NB), .WORD_W(W), .SEL_W(SW)) bus ();

    hash_state_bank #(.NUM_BANKS(NB), .WORD_W(W), .SEL_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic           is_err;
        logic [STW-1:0] state;
        int             cyc;
        string          tag;
    } exp_t;

    exp_t           expQ [$];
    exp_t           e;
    int             compared   = 0;
    int             mismatched = 0;
    int             cyc        = 0;

    logic [W-1:0]   ivWords [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                                    32'ha54ff53a, 32'h510e527f, 32'h9b05688c,
                                    32'h1f83d9ab, 32'h5be0cd19};
    logic [W-1:0]   mBank [NB][8];
    logic [NB-1:0]  mDirty;
    logic [STW-1:0] mLast;

    // The edge counter lets the monitor check the exact one-cycle read latency.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [STW-1:0] packBank(input int b);
        logic [STW-1:0] r;
        for (int w = 0; w < 8; w++) r[(7-w)*W +: W] = mBank[b][w];
        return r;
    endfunction

    task automatic modelReset();
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < 8; w++) mBank[b][w] = ivWords[w];
        mDirty = '0;
        mLast  = '0;
        expQ.delete();
    endtask

    task automatic checkOutput(input string name, input logic [STW-1:0] act,
                               input logic [STW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        bus.rd_req   = 1'b0;
        bus.rd_sel   = '0;
        bus.wr_en    = 1'b0;
        bus.wr_sel   = '0;
        bus.wr_state = '0;
        bus.init_en  = 1'b0;
        bus.init_sel = '0;
    endtask

    // Drive one cycle of requests. The expected read comes from the model
    // before the write is applied (read-first). Init overrides the write.
    task automatic applyStimulus(input bit rd, input int rs, input bit wr,
                                 input int ws, input logic [STW-1:0] wd,
                                 input bit ini, input int is, input string tag);
        exp_t x;
        logic [W-1:0] word;
        bus.rd_req   = rd;
        bus.rd_sel   = SW'(rs);
        bus.wr_en    = wr;
        bus.wr_sel   = SW'(ws);
        bus.wr_state = wd;
        bus.init_en  = ini;
        bus.init_sel = SW'(is);
        if (rd) begin
            if (rs < NB) begin
                mLast    = packBank(rs);
                x.is_err = 1'b0;
            end else begin
                x.is_err = 1'b1;
            end
            x.state = mLast;
            x.cyc   = cyc;
            x.tag   = tag;
            expQ.push_back(x);
        end
        if (wr && ws < NB) begin
            for (int w = 0; w < 8; w++) begin
                word = wd[(7-w)*W +: W];
`ifdef HASH_STATE_BANK_ACCUM_EN
                mBank[ws][w] = mBank[ws][w] + word;
`else
                mBank[ws][w] = word;
`endif
            end
            mDirty[ws] = 1'b1;
        end
        if (ini && is < NB) begin
            for (int w = 0; w < 8; w++) mBank[is][w] = ivWords[w];
            mDirty[is] = 1'b0;
        end
        @(posedge clk); #1;
        clearInputs();
        checkOutput({tag, " dirty"}, STW'(bus.bank_dirty), STW'(mDirty));
    endtask

    // Count the cycles with busy high. Stray requests are driven meanwhile;
    // the DUT must ignore them.
    task automatic waitInit(input string tag);
        int n = 0;
        for (int k = 0; k < 20 && bus.busy; k++) begin
            n++;
            bus.rd_req   = 1'b1;
            bus.rd_sel   = SW'(k % NB);
            bus.wr_en    = 1'b1;
            bus.wr_sel   = SW'(1);
            bus.wr_state = {8{$urandom}};
            @(posedge clk); #1;
        end
        clearInputs();
        checkOutput({tag, " busy cycles"}, STW'(n), STW'(NB));
        checkOutput({tag, " dirty after init"}, STW'(bus.bank_dirty), '0);
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        clearInputs();
        repeat (n) @(posedge clk);
        #1;
        checkOutput("reset rd_valid", STW'(bus.rd_valid), '0);
        checkOutput("reset rd_err", STW'(bus.rd_err), '0);
        checkOutput("reset rd_state", bus.rd_state, '0);
        checkOutput("reset busy", STW'(bus.busy), STW'(1));
        checkOutput("reset dirty", STW'(bus.bank_dirty), '0);
        modelReset();
        rst = 1'b0;
    endtask

    // Monitor: every pulse must match the next queued response, one cycle
    // after it was issued. A response that is still queued after its cycle
    // has passed is reported as missing.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_valid || bus.rd_err) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected pulse: valid=%b err=%b, expected none",
                             bus.rd_valid, bus.rd_err);
                end else begin
                    e = expQ.pop_front();
                    if (bus.rd_err !== e.is_err || bus.rd_valid !== !e.is_err ||
                        bus.rd_state !== e.state || cyc != e.cyc + 1) begin
                        mismatched++;
                        $display("[TB] FAIL %s: got v=%b e=%b cyc=%0d %h, expected v=%b e=%b cyc=%0d %h",
                                 e.tag, bus.rd_valid, bus.rd_err, cyc, bus.rd_state,
                                 !e.is_err, e.is_err, e.cyc + 1, e.state);
                    end
                end
            end else if (expQ.size() > 0 && cyc >= expQ[0].cyc + 1) begin
                e = expQ.pop_front();
                compared++;
                mismatched++;
                $display("[TB] FAIL %s: got no pulse, expected v=%b e=%b",
                         e.tag, !e.is_err, e.is_err);
            end
        end
    end

    logic [STW-1:0] rdata;
    initial begin
        clearInputs();
        doReset(2);
        waitInit("post-reset");

        applyStimulus(1, 2, 0, 0, '0, 0, 0, "iv read bank2");

        applyStimulus(0, 0, 1, 1, {8{32'h00000001}}, 0, 0, "write bank1");
        applyStimulus(1, 1, 0, 0, '0, 0, 0, "read bank1");
        checkOutput("dirty 0010", STW'(bus.bank_dirty), STW'(4'b0010));

        applyStimulus(0, 0, 1, 0, {8{32'h00000001}}, 0, 0, "write bank0 ones");
        applyStimulus(1, 0, 0, 0, '0, 0, 0, "read bank0 ones");
        applyStimulus(0, 0, 1, 0, {32'hffffffff, 224'h0}, 0, 0, "write bank0 A");
        applyStimulus(1, 0, 0, 0, '0, 0, 0, "read bank0 A");

        applyStimulus(0, 0, 1, 3, {8{32'hdeadbeef}}, 1, 3, "collision bank3");
        applyStimulus(1, 3, 0, 0, '0, 0, 0, "read bank3 after collision");

        for (int w = 0; w < 8; w++) rdata[w*W +: W] = $urandom;
        applyStimulus(1, 0, 1, 0, rdata, 0, 0, "read during write");
        applyStimulus(1, 0, 0, 0, '0, 0, 0, "read after write");

        applyStimulus(1, 5, 0, 0, '0, 0, 0, "out of range read");
        applyStimulus(1, 2, 1, 7, rdata, 1, 9, "oor write/init");

        for (int k = 0; k < 300; k++) begin
            for (int w = 0; w < 8; w++) rdata[w*W +: W] = $urandom;
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 5),
                          $urandom_range(0, 1) != 0, $urandom_range(0, 5), rdata,
                          $urandom_range(0, 5) == 0, $urandom_range(0, 5), "random");
        end

        // Reset in the middle of the init sequence, when the bank counter is 2.
        doReset(1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        doReset(1);
        waitInit("mid-init reset");
        applyStimulus(1, 3, 0, 0, '0, 0, 0, "read bank3 after reinit");

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", STW'(expQ.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
